// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier.
//   state_t           : FSM encoding (IDLE, RUN, FINAL)
//   num_steps()       : number of digit steps N = width / bits-per-cycle
//   bpc_is_legal()    : legal bits-per-cycle set {1, 2, 4}
package mult_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t FINAL = 2'd2;

   function automatic int unsigned num_steps(input int unsigned width, input int unsigned bpc);
      return width / bpc;
   endfunction

   function automatic bit bpc_is_legal(input int unsigned bpc);
      return (bpc == 1) || (bpc == 2) || (bpc == 4);
   endfunction

endpackage

// File: rtl/mult_step.sv
// Combinational partial-product step.
//   mcand     : unsigned multiplicand magnitude
//   digit     : current BITS_PER_CYCLE-bit multiplier digit
//   acc_slice : upper WIDTH bits of the accumulator
//   acc_next  : acc_slice + mcand * digit (WIDTH+BITS_PER_CYCLE bits, cannot overflow)
module mult_step
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0]                mcand,
   input  logic [BITS_PER_CYCLE-1:0]       digit,
   input  logic [WIDTH-1:0]                acc_slice,
   output logic [WIDTH+BITS_PER_CYCLE-1:0] acc_next
);

   localparam int unsigned SW = WIDTH + BITS_PER_CYCLE;

   always_comb begin
      acc_next = SW'(mcand) * SW'(digit) + SW'(acc_slice);
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned WIDTH x WIDTH multiplier with HI/LO result registers.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start      : request a multiply (accepted only when idle)
//   is_signed  : treat a/b as two's complement
//   a, b       : multiplicand / multiplier, sampled with start
//   busy       : operation in flight (stall request)
//   done       : one-cycle pulse, hi/lo valid from this cycle
//   hi, lo     : upper / lower halves of the product, held until next completion
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned N  = num_steps(WIDTH, BITS_PER_CYCLE);
   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned AW = 2 * WIDTH;

   if (!bpc_is_legal(BITS_PER_CYCLE) || ((WIDTH % BITS_PER_CYCLE) != 0) || (WIDTH < 4) ||
       ((WIDTH % 2) != 0)) begin : g_bad_cfg
      $error("seq_multiplier: illegal WIDTH / BITS_PER_CYCLE combination");
   end

   state_t                   state_q, state_d;
   logic [CW-1:0]            count_q, count_d;
   logic [WIDTH-1:0]         mcand_q, mcand_d;
   logic [WIDTH-1:0]         mplier_q, mplier_d;
   logic [AW-1:0]            acc_q, acc_d;
   logic                     neg_q, neg_d;
   logic [WIDTH-1:0]         hi_q, hi_d;
   logic [WIDTH-1:0]         lo_q, lo_d;
   logic                     done_q, done_d;
   logic                     busy_q, busy_d;

   logic [WIDTH+BITS_PER_CYCLE-1:0] step_sum;
   logic [AW-1:0]                   acc_step;
   logic [AW-1:0]                   result;

   mult_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .mcand     (mcand_q),
      .digit     (mplier_q[BITS_PER_CYCLE-1:0]),
      .acc_slice (acc_q[AW-1:WIDTH]),
      .acc_next  (step_sum)
   );

   // The partial product is added to the upper half and the whole accumulator
   // shifts right by one digit, so after N steps it holds the full product.
   always_comb begin
      acc_step = AW'({step_sum, acc_q[WIDTH-1:0]} >> BITS_PER_CYCLE);
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      result   = acc_step;

      case (state_q)
         IDLE: begin
            if (start) begin
               // |most negative| = 2^(WIDTH-1) still fits the unsigned register.
               mcand_d  = (is_signed && a[WIDTH-1]) ? WIDTH'(0) - a : a;
               mplier_d = (is_signed && b[WIDTH-1]) ? WIDTH'(0) - b : b;
               neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               count_d  = CW'(N);
               state_d  = (N == 1) ? FINAL : RUN;
            end
         end
         RUN: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            count_d  = count_q - CW'(1);
            if (count_d == CW'(1)) begin
               state_d = FINAL;
            end
         end
         FINAL: begin
            // Last digit is retired here together with the sign fix-up.
            acc_d    = acc_step;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            count_d  = count_q - CW'(1);
            result   = neg_q ? AW'(0) - acc_step : acc_step;
            hi_d     = result[AW-1:WIDTH];
            lo_d     = result[WIDTH-1:0];
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: nine seq_multiplier instances (WIDTH 8/16/32 x BPC 1/2/4) share the
// stimulus; directed scenarios target the 32-bit instances, random runs check all of them
// against an arithmetic reference product.
module tb_seq_multiplier;

   localparam int NI  = 9;
   localparam int I32 = 6;   // WIDTH=32, BPC=1
   localparam int I4  = 8;   // WIDTH=32, BPC=4

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a_in;
   logic [31:0] b_in;

   wire [NI-1:0] busy_v;
   wire [NI-1:0] done_v;
   wire [31:0]   hi_v [NI];
   wire [31:0]   lo_v [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int unsigned W = (gi / 3 == 0) ? 8 : ((gi / 3 == 1) ? 16 : 32);
      localparam int unsigned B = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 2 : 4);
      logic [W-1:0] hi_w;
      logic [W-1:0] lo_w;
      seq_multiplier #(
         .WIDTH          (W),
         .BITS_PER_CYCLE (B)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .start     (start),
         .is_signed (is_signed),
         .a         (a_in[W-1:0]),
         .b         (b_in[W-1:0]),
         .busy      (busy_v[gi]),
         .done      (done_v[gi]),
         .hi        (hi_w),
         .lo        (lo_w)
      );
      assign hi_v[gi] = 32'(hi_w);
      assign lo_v[gi] = 32'(lo_w);
   end

   function automatic int unsigned w_of(input int i);
      return (i / 3 == 0) ? 8 : ((i / 3 == 1) ? 16 : 32);
   endfunction

   function automatic int unsigned b_of(input int i);
      return (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 4);
   endfunction

   // Reference: interpret low w bits as signed/unsigned integers, multiply in 64 bits.
   function automatic logic [63:0] ref_prod(input int unsigned w, input logic s,
                                            input logic [31:0] x, input logic [31:0] y);
      logic [63:0] mask, xv, yv;
      mask = (64'd1 << w) - 64'd1;
      xv   = {32'd0, x} & mask;
      yv   = {32'd0, y} & mask;
      if (s) begin
         if (xv[w-1]) xv = xv | ~mask;
         if (yv[w-1]) yv = yv | ~mask;
      end
      return xv * yv;
   endfunction

   function automatic logic [31:0] ref_hi(input int unsigned w, input logic [63:0] p);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      return 32'((p >> w) & mask);
   endfunction

   function automatic logic [31:0] ref_lo(input int unsigned w, input logic [63:0] p);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      return 32'(p & mask);
   endfunction

   task automatic wait_idle();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (busy_v == '0) return;
      end
      errors++;
      $display("FAIL wait_idle: busy=%b still set after 100 cycles", busy_v);
   endtask

   // Returns at the negedge just after the accepting edge.
   task automatic do_start(input logic s, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      is_signed = s;
      a_in      = x;
      b_in      = y;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      is_signed = 1'($urandom);
      a_in      = $urandom;
      b_in      = $urandom;
   endtask

   task automatic wait_done(input int idx, input int limit, output int cyc);
      cyc = -1;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_v[idx]) begin
            cyc = k;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      a_in      = '0;
      b_in      = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if ({busy_v[i], done_v[i]} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags[%0d]: busy,done=%b required 00", i,
                     {busy_v[i], done_v[i]});
         end
         checks++;
         if ({hi_v[i], lo_v[i]} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo[%0d]: got %h_%h required 0", i, hi_v[i], lo_v[i]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_unsigned_max();
      int  cyc;
      bit  busy_bad;
      wait_idle();
      do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc      = -1;
      busy_bad = 1'b0;
      if (busy_v[I32] !== 1'b1) busy_bad = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_v[I32]) begin
            cyc = k;
            break;
         end
         if (busy_v[I32] !== 1'b1) busy_bad = 1'b1;
      end
      checks++;
      if (busy_bad) begin
         errors++;
         $display("FAIL umax_busy: busy dropped before done, required high throughout");
      end
      checks++;
      if (cyc != 32) begin
         errors++;
         $display("FAIL umax_latency: got %0d cycles required 32", cyc);
      end
      checks++;
      if (busy_v[I32] !== 1'b0) begin
         errors++;
         $display("FAIL umax_busy_at_done: got %b required 0", busy_v[I32]);
      end
      checks++;
      if (hi_v[I32] !== 32'hFFFF_FFFE || lo_v[I32] !== 32'h0000_0001) begin
         errors++;
         $display("FAIL umax_result: got %h_%h required fffffffe_00000001", hi_v[I32],
                  lo_v[I32]);
      end
      @(negedge clk);
      checks++;
      if (done_v[I32] !== 1'b0) begin
         errors++;
         $display("FAIL umax_done_pulse: done still %b one cycle later, required 0",
                  done_v[I32]);
      end
   endtask

   task automatic test_signed();
      logic [31:0] xs [2];
      logic [31:0] ys [2];
      logic [31:0] eh [2];
      logic [31:0] el [2];
      int          cyc;
      xs[0] = 32'hFFFF_FFFF; ys[0] = 32'h0000_0001; eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFFF;
      xs[1] = 32'h8000_0000; ys[1] = 32'h8000_0000; eh[1] = 32'h4000_0000; el[1] = 32'h0000_0000;
      for (int t = 0; t < 2; t++) begin
         wait_idle();
         do_start(1'b1, xs[t], ys[t]);
         wait_done(I32, 40, cyc);
         checks++;
         if (cyc != 32) begin
            errors++;
            $display("FAIL signed_latency[%0d]: got %0d required 32", t, cyc);
         end
         checks++;
         if (hi_v[I32] !== eh[t] || lo_v[I32] !== el[t]) begin
            errors++;
            $display("FAIL signed_bpc1[%0d]: got %h_%h required %h_%h", t, hi_v[I32],
                     lo_v[I32], eh[t], el[t]);
         end
         checks++;
         if (hi_v[I4] !== eh[t] || lo_v[I4] !== el[t]) begin
            errors++;
            $display("FAIL signed_bpc4[%0d]: got %h_%h required %h_%h", t, hi_v[I4],
                     lo_v[I4], eh[t], el[t]);
         end
      end
   endtask

   task automatic test_radix4();
      int cyc;
      wait_idle();
      do_start(1'b1, 32'd7, 32'hFFFF_FFFD);
      wait_done(I4, 20, cyc);
      checks++;
      if (cyc != 8) begin
         errors++;
         $display("FAIL r4_latency_s: got %0d required 8", cyc);
      end
      checks++;
      if (hi_v[I4] !== 32'hFFFF_FFFF || lo_v[I4] !== 32'hFFFF_FFEB) begin
         errors++;
         $display("FAIL r4_signed: got %h_%h required ffffffff_ffffffeb", hi_v[I4], lo_v[I4]);
      end
      wait_idle();
      do_start(1'b0, 32'd7, 32'hFFFF_FFFD);
      wait_done(I4, 20, cyc);
      checks++;
      if (cyc != 8) begin
         errors++;
         $display("FAIL r4_latency_u: got %0d required 8", cyc);
      end
      checks++;
      if (hi_v[I4] !== 32'h0000_0006 || lo_v[I4] !== 32'hFFFF_FFEB) begin
         errors++;
         $display("FAIL r4_unsigned: got %h_%h required 00000006_ffffffeb", hi_v[I4],
                  lo_v[I4]);
      end
   endtask

   task automatic test_ignored_start();
      logic [31:0] x, y;
      logic [63:0] p;
      int          cyc;
      x = $urandom;
      y = $urandom;
      p = ref_prod(32, 1'b1, x, y);
      wait_idle();
      do_start(1'b1, x, y);
      repeat (5) @(negedge clk);
      is_signed = 1'b0;
      a_in      = ~x;
      b_in      = y ^ 32'h5A5A_5A5A;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(I32, 40, cyc);
      checks++;
      if (cyc != 26) begin
         errors++;
         $display("FAIL ignore_latency: got %0d cycles after stray start required 26", cyc);
      end
      checks++;
      if (hi_v[I32] !== ref_hi(32, p) || lo_v[I32] !== ref_lo(32, p)) begin
         errors++;
         $display("FAIL ignore_result: got %h_%h required %h_%h", hi_v[I32], lo_v[I32],
                  ref_hi(32, p), ref_lo(32, p));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x1, y1, x2, y2;
      logic [63:0] p1, p2;
      int          cyc;
      x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
      p1 = ref_prod(32, 1'b0, x1, y1);
      p2 = ref_prod(32, 1'b1, x2, y2);
      wait_idle();
      do_start(1'b0, x1, y1);
      wait_done(I4, 20, cyc);
      checks++;
      if (hi_v[I4] !== ref_hi(32, p1) || lo_v[I4] !== ref_lo(32, p1)) begin
         errors++;
         $display("FAIL b2b_first: got %h_%h required %h_%h", hi_v[I4], lo_v[I4],
                  ref_hi(32, p1), ref_lo(32, p1));
      end
      // New request presented in the done cycle.
      is_signed = 1'b1;
      a_in      = x2;
      b_in      = y2;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy_v[I4] !== 1'b1 || done_v[I4] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: busy,done=%b%b required 10", busy_v[I4], done_v[I4]);
      end
      checks++;
      if (hi_v[I4] !== ref_hi(32, p1) || lo_v[I4] !== ref_lo(32, p1)) begin
         errors++;
         $display("FAIL b2b_hold: got %h_%h required %h_%h", hi_v[I4], lo_v[I4],
                  ref_hi(32, p1), ref_lo(32, p1));
      end
      wait_done(I4, 20, cyc);
      checks++;
      if (cyc != 8) begin
         errors++;
         $display("FAIL b2b_latency: got %0d required 8", cyc);
      end
      checks++;
      if (hi_v[I4] !== ref_hi(32, p2) || lo_v[I4] !== ref_lo(32, p2)) begin
         errors++;
         $display("FAIL b2b_second: got %h_%h required %h_%h", hi_v[I4], lo_v[I4],
                  ref_hi(32, p2), ref_lo(32, p2));
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] x, y;
      logic [63:0] p;
      int          cyc;
      bit          saw_done;
      wait_idle();
      do_start(1'b1, 32'h1234_5678, 32'h8765_4321);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (busy_v[I32] !== 1'b0 || done_v[I32] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_flags: busy,done=%b%b required 00", busy_v[I32], done_v[I32]);
      end
      checks++;
      if (hi_v[I32] !== 32'd0 || lo_v[I32] !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_hilo: got %h_%h required 0", hi_v[I32], lo_v[I32]);
      end
      @(negedge clk);
      reset    = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_v[I32]) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL rst_mid_no_done: done pulsed after abort, required none");
      end
      x = $urandom;
      y = $urandom;
      p = ref_prod(32, 1'b1, x, y);
      do_start(1'b1, x, y);
      wait_done(I32, 40, cyc);
      checks++;
      if (cyc != 32 || hi_v[I32] !== ref_hi(32, p) || lo_v[I32] !== ref_lo(32, p)) begin
         errors++;
         $display("FAIL rst_mid_next: got %0d cycles %h_%h required 32 cycles %h_%h", cyc,
                  hi_v[I32], lo_v[I32], ref_hi(32, p), ref_lo(32, p));
      end
   endtask

   task automatic test_random();
      logic [31:0] x, y;
      logic        s;
      logic [63:0] p;
      logic [31:0] exp_hi [NI];
      logic [31:0] exp_lo [NI];
      bit          seen   [NI];
      for (int it = 0; it < 30; it++) begin
         s = 1'($urandom);
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: x = 32'hFFFF_FFFF;
            1: y = 32'd0;
            2: begin x = 32'h8080_8080; y = 32'h8080_8080; end
            default: ;
         endcase
         for (int i = 0; i < NI; i++) begin
            p         = ref_prod(w_of(i), s, x, y);
            exp_hi[i] = ref_hi(w_of(i), p);
            exp_lo[i] = ref_lo(w_of(i), p);
            seen[i]   = 1'b0;
         end
         wait_idle();
         do_start(s, x, y);
         for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
               if (done_v[i] && !seen[i]) begin
                  seen[i] = 1'b1;
                  checks++;
                  if (k != int'(w_of(i) / b_of(i))) begin
                     errors++;
                     $display("FAIL rand_latency[w%0d b%0d]: got %0d required %0d", w_of(i),
                              b_of(i), k, w_of(i) / b_of(i));
                  end
                  checks++;
                  if (hi_v[i] !== exp_hi[i] || lo_v[i] !== exp_lo[i]) begin
                     errors++;
                     $display("FAIL rand_result[w%0d b%0d s%0d %h*%h]: got %h_%h required %h_%h",
                              w_of(i), b_of(i), s, x, y, hi_v[i], lo_v[i], exp_hi[i],
                              exp_lo[i]);
                  end
               end
            end
         end
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (!seen[i]) begin
               errors++;
               $display("FAIL rand_timeout[w%0d b%0d]: no done within 40 cycles", w_of(i),
                        b_of(i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed();
      test_radix4();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
